fifo_word_packer: RTL and testbench
===================================

// Module: fifo_word_packer
// PURPOSE
//  Read-side engine for the nibble FIFO: pops DATA_W-bit entries through the FIFO's ren/empty/rdata port.
//  Packs NIBBLES entries into one word and presents it downstream on a valid/ready stream.
//  FIFO rdata is show-ahead: it is valid whenever empty=0 and is sampled in the same cycle ren is high.
//  Sits between the FIFO and the word-wide consumer.
// PARAMETERS
//  DATA_W   4  width of one FIFO entry
//  NIBBLES  4  entries per output word; legal range 2..8
//  TIMEOUT  8  idle cycles before a partial word is flushed; used only with FIFO_PACKER_TIMEOUT_EN; >=1
// PORTS
//  CLK        in   1                 clock; all state updates on posedge
//  RESETN     in   1                 asynchronous active-low reset
//  fifo_rdata in   DATA_W            FIFO head entry
//  fifo_empty in   1                 FIFO empty flag
//  fifo_ren   out  1                 FIFO pop strobe (combinational)
//  out_data   out  DATA_W*NIBBLES    packed word; first-popped entry in bits [DATA_W-1:0]
//  out_count  out  $clog2(NIBBLES)+1 number of valid entries in out_data
//  out_valid  out  1                 word available
//  out_ready  in   1                 consumer accepts word when out_valid & out_ready
//  busy       out  1                 high when idx!=0 or out_valid=1
// BEHAVIOUR
//  Reset (RESETN=0, asynchronous): state=FILL, idx=0, out_data=0, out_count=0, out_valid=0, busy=0.
//   fifo_ren is forced to 0 while RESETN=0.
//  Pop rule: a pop occurs in a cycle iff fifo_ren=1. fifo_ren is never high while fifo_empty=1.
//  State FILL (out_valid=0):
//   - fifo_ren = ~fifo_empty.
//   - On a pop, fifo_rdata is written to slot idx and idx increments.
//   - The pop that fills slot NIBBLES-1 moves the block to HOLD: out_valid=1 the next cycle, out_count=NIBBLES, idx=0.
//   - Latency: out_valid rises one cycle after the final pop.
//  State HOLD (out_valid=1):
//   - out_data and out_count are stable until accepted.
//   - fifo_ren = out_ready & ~fifo_empty.
//   - Accept (out_ready=1): next cycle out_valid=0, out_count=0, state=FILL, and all slots are cleared to 0.
//   - If a pop coincides with the accept, that entry becomes slot 0 of the next word and idx=1.
//   - Sustained throughput: one word per NIBBLES cycles, no bubble.
//   - out_ready=0: no pops; the FIFO fills and stalls its writer.
//  out_ready is ignored while out_valid=0. Unfilled slots are always 0.
//  Reset mid-word or mid-HOLD discards all packed data; the FIFO contents are untouched.
// CONFIGURATION
//  FIFO_PACKER_TIMEOUT_EN defined:
//   - An idle counter runs in FILL while idx>0 and there is no pop. It clears on any pop and on entry to FILL.
//   - When the counter reaches TIMEOUT, HOLD is entered next cycle with out_count=idx and zero upper slots.
//   - A pop in the timeout cycle itself takes precedence; no flush happens that cycle.
//  FIFO_PACKER_TIMEOUT_EN undefined:
//   - No idle counter; a partial word waits indefinitely.
//   - out_count is always NIBBLES when out_valid=1; TIMEOUT is unused.
// TESTING
//  1 Reset: RESETN=0 with fifo_empty=0 -> fifo_ren=0, out_valid=0, out_data=0 immediately (no clock edge needed).
//  2 Stream: FIFO holds 1,2,3,4; out_ready=1 -> 4 consecutive pops.
//    out_valid=1 the cycle after the 4th pop, out_data=16'h4321, out_count=4.
//  3 Backpressure: FIFO holds 1..8; out_ready=0 -> exactly 4 pops, then fifo_ren=0 and out_data=16'h4321 held.
//    Raise out_ready -> same-cycle pop of 5; next word=16'h8765.
//  4 Gaps: toggle fifo_empty every cycle while supplying A,B,C,D -> no pop while empty.
//    out_data=16'hDCBA, out_count=4.
//  5 Timeout (macro defined): push A,B then empty for 8 cycles -> out_valid=1, out_data=16'h00BA, out_count=2.
//    Same stimulus without the macro -> out_valid stays 0 and busy=1.
//  6 Reset mid-HOLD: out_valid=1, pulse RESETN low -> out_valid=0 at once.
//    Following words pack from slot 0 with correct data.

Source files
------------

// File: rtl/fifo_word_packer.sv
// Pops NIBBLES show-ahead FIFO entries and packs them into one word on a valid/ready stream.
// Optional partial-word flush after TIMEOUT idle cycles when FIFO_PACKER_TIMEOUT_EN is defined.
module fifo_word_packer #(
    parameter int DATA_W  = 4,
    parameter int NIBBLES = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                           CLK,
    input  logic                           RESETN,
    input  logic [DATA_W-1:0]              fifo_rdata,
    input  logic                           fifo_empty,
    output logic                           fifo_ren,
    output logic [DATA_W*NIBBLES-1:0]      out_data,
    output logic [$clog2(NIBBLES):0]       out_count,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy
);

    localparam int CNT_W = $clog2(NIBBLES) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NIBBLES);

    if (NIBBLES < 2 || NIBBLES > 8 || TIMEOUT < 1) begin : g_param_check
        $error("fifo_word_packer: NIBBLES must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             pop;
    logic             wr_en;
    logic [CNT_W-1:0] wr_idx;
    logic             clr_slots;

`ifdef FIFO_PACKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_reg, idle_next;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_reg <= FILL;
            idx_reg   <= '0;
            count_reg <= '0;
`ifdef FIFO_PACKER_TIMEOUT_EN
            idle_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            count_reg <= count_next;
`ifdef FIFO_PACKER_TIMEOUT_EN
            idle_reg  <= idle_next;
`endif
        end
    end

    always_comb begin
        pop        = ~fifo_empty & ((state_reg == FILL) | out_ready);
        state_next = state_reg;
        idx_next   = idx_reg;
        count_next = count_reg;
        wr_en      = 1'b0;
        wr_idx     = idx_reg;
        clr_slots  = 1'b0;
`ifdef FIFO_PACKER_TIMEOUT_EN
        idle_next  = idle_reg;
`endif
        case (state_reg)
            FILL: begin
                if (pop) begin
                    wr_en = 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_next = HOLD;
                        count_next = FULL_CNT;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
`ifdef FIFO_PACKER_TIMEOUT_EN
                // A pop always wins over the flush; the counter only ages a started word.
                if (pop) begin
                    idle_next = '0;
                end else if (idx_reg != '0) begin
                    if (idle_reg == IDLE_W'(TIMEOUT)) begin
                        state_next = HOLD;
                        count_next = idx_reg;
                        idx_next   = '0;
                        idle_next  = '0;
                    end else begin
                        idle_next = idle_reg + 1'b1;
                    end
                end
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = FILL;
                    count_next = '0;
                    clr_slots  = 1'b1;
`ifdef FIFO_PACKER_TIMEOUT_EN
                    idle_next  = '0;
`endif
                    // An entry popped on the accepting edge starts the next word.
                    if (pop) begin
                        wr_en    = 1'b1;
                        wr_idx   = '0;
                        idx_next = CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_slot
        logic [DATA_W-1:0] slot_reg;

        always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
                slot_reg <= '0;
            end else if (wr_en && (wr_idx == CNT_W'(gi))) begin
                slot_reg <= fifo_rdata;
            end else if (clr_slots) begin
                slot_reg <= '0;
            end
        end

        assign out_data[gi*DATA_W +: DATA_W] = slot_reg;
    end

    assign fifo_ren  = pop & RESETN;
    assign out_valid = (state_reg == HOLD);
    assign out_count = count_reg;
    assign busy      = (idx_reg != '0) | (state_reg == HOLD);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: FIFO model feeds the packer, a scoreboard checks every accepted word.
module tb_fifo_word_packer;

    logic        CLK;
    logic        RESETN;
    logic [3:0]  fifo_rdata;
    logic        fifo_empty;
    logic        fifo_ren;
    logic [15:0] out_data;
    logic [2:0]  out_count;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          pop_count = 0;
    logic        hold_empty;
    logic [18:0] exp_q [$];

    fifo_word_packer dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign fifo_empty = hold_empty | (rd_ptr == wr_ptr);
    assign fifo_rdata = mem[rd_ptr % 64];

    always @(posedge CLK) begin
        if (fifo_ren) begin
            rd_ptr    <= rd_ptr + 1;
            pop_count <= pop_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] v);
        mem[wr_ptr % 64] = v;
        wr_ptr++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: every accepted word must match the oldest expected word.
    always @(negedge CLK) begin
        if (RESETN && fifo_empty) check("ren_while_empty", {31'd0, fifo_ren}, 32'd0);
        if (RESETN && out_valid && out_ready) begin
            $display("word accepted data=%h count=%0d", out_data, out_count);
            check("word_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                logic [18:0] e;
                e = exp_q.pop_front();
                check("word_data", {16'd0, out_data}, {16'd0, e[15:0]});
                check("word_count", {29'd0, out_count}, {29'd0, e[18:16]});
            end
        end
    end

    task automatic wait_drain(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !out_valid && !busy && fifo_empty) done = 1'b1;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int base;
        logic seen;

        RESETN     = 1'b0;
        out_ready  = 1'b0;
        hold_empty = 1'b0;

        // Reset with a non-empty FIFO: no pop, cleared outputs, no clock needed.
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        #1;
        check("rst_ren", {31'd0, fifo_ren}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        check("rst_count", {29'd0, out_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Stream 1..4: out_valid rises on the cycle after the 4th pop.
        tick();
        RESETN    = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back({3'd4, 16'h4321});
        base = pop_count;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (pop_count - base == 3) check("stream_pre_valid", {31'd0, out_valid}, 32'd0);
            if (pop_count - base == 4) begin
                seen = 1'b1;
                check("stream_valid", {31'd0, out_valid}, 32'd1);
                check("stream_data", {16'd0, out_data}, 32'h4321);
                check("stream_count", {29'd0, out_count}, 32'd4);
            end
        end
        check("stream_seen", {31'd0, seen}, 32'd1);
        wait_drain("stream_drain");

        // Backpressure: exactly one word's worth of pops, then the word is held.
        tick();
        out_ready = 1'b0;
        base = pop_count;
        for (int v = 1; v <= 8; v++) push(4'(v));
        exp_q.push_back({3'd4, 16'h4321});
        exp_q.push_back({3'd4, 16'h8765});
        repeat (10) @(negedge CLK);
        check("bp_pops", pop_count - base, 32'd4);
        check("bp_ren", {31'd0, fifo_ren}, 32'd0);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_data", {16'd0, out_data}, 32'h4321);
        check("bp_busy", {31'd0, busy}, 32'd1);
        tick();
        out_ready = 1'b1;
        @(negedge CLK);
        check("bp_same_cycle_pop", {31'd0, fifo_ren}, 32'd1);
        repeat (3) @(negedge CLK);
        check("bp_next_pre_valid", {31'd0, out_valid}, 32'd0);
        @(negedge CLK);
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_data", {16'd0, out_data}, 32'h8765);
        wait_drain("bp_drain");

        // Gaps: the FIFO flickers empty every other cycle.
        base = pop_count;
        push(4'hA); push(4'hB); push(4'hC); push(4'hD);
        exp_q.push_back({3'd4, 16'hDCBA});
        for (int i = 0; i < 12; i++) begin
            tick();
            hold_empty = (i % 2 == 0);
            @(negedge CLK);
            if (fifo_empty) check("gap_no_pop", {31'd0, fifo_ren}, 32'd0);
        end
        tick();
        hold_empty = 1'b0;
        wait_drain("gap_drain");
        check("gap_pops", pop_count - base, 32'd4);

        // Partial word A,B followed by a long idle stretch.
        base = pop_count;
        push(4'hA); push(4'hB);
`ifdef FIFO_PACKER_TIMEOUT_EN
        exp_q.push_back({3'd2, 16'h00BA});
        wait_drain("timeout_flush");
`else
        repeat (16) @(negedge CLK);
        check("no_timeout_valid", {31'd0, out_valid}, 32'd0);
        check("no_timeout_busy", {31'd0, busy}, 32'd1);
`endif
        check("partial_pops", pop_count - base, 32'd2);

        tick();
        RESETN = 1'b0;
        #1;
        check("rst2_busy", {31'd0, busy}, 32'd0);
        check("rst2_valid", {31'd0, out_valid}, 32'd0);
        tick();
        RESETN = 1'b1;

        // Reset while holding a word discards it; packing restarts at slot 0.
        out_ready = 1'b0;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (out_valid) seen = 1'b1;
        end
        check("hold_seen", {31'd0, seen}, 32'd1);
        check("hold_data", {16'd0, out_data}, 32'h4321);
        tick();
        RESETN = 1'b0;
        #1;
        check("rst3_valid", {31'd0, out_valid}, 32'd0);
        check("rst3_data", {16'd0, out_data}, 32'd0);
        check("rst3_count", {29'd0, out_count}, 32'd0);
        tick();
        RESETN    = 1'b1;
        out_ready = 1'b1;
        push(4'h5); push(4'h6); push(4'h7); push(4'h8);
        exp_q.push_back({3'd4, 16'h8765});
        wait_drain("after_reset_drain");
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
